// File: rtl/axis_demux_route_ctrl.sv
// Packet-granular route controller for an AXI-Stream demux (select held per packet).
// Optional stall watchdog: define AXIS_DEMUX_ROUTE_TIMEOUT_EN to add it and the timeout port.
module axis_demux_route_ctrl #(
    parameter int CHANNEL_NUMBER       = 5,
    parameter int CHANNEL_NUMBER_WIDTH = $clog2(CHANNEL_NUMBER),
    parameter int DEST_WIDTH           = 4,
    parameter int DEFAULT_CHANNEL      = 0,
    parameter int TIMEOUT_CYCLES       = 256
) (
    input  logic                            aclk,
    input  logic                            aresetn,
    input  logic                            in_tvalid,
    input  logic                            in_tready,
    input  logic                            in_tlast,
    input  logic [DEST_WIDTH-1:0]           in_tdest,
    output logic                            en,
    output logic [CHANNEL_NUMBER_WIDTH-1:0] ctrl,
    output logic                            busy,
    output logic                            dest_err,
    output logic [15:0]                     pkt_count
`ifdef AXIS_DEMUX_ROUTE_TIMEOUT_EN
    ,
    output logic                            timeout
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t                            state;
    logic [CHANNEL_NUMBER_WIDTH-1:0]   route;
    logic [CHANNEL_NUMBER_WIDTH-1:0]   sel;
    logic                              in_range;
    logic                              beat;

    assign beat     = in_tvalid & in_tready;
    // Full-width compare so high tdest bits can never alias a valid channel
    assign in_range = 32'(in_tdest) < 32'(CHANNEL_NUMBER);
    assign sel      = in_range ? CHANNEL_NUMBER_WIDTH'(in_tdest)
                               : CHANNEL_NUMBER_WIDTH'(DEFAULT_CHANNEL);

    assign busy = (state == BUSY);
    assign en   = busy | in_tvalid;
    assign ctrl = busy ? route : sel;

`ifdef AXIS_DEMUX_ROUTE_TIMEOUT_EN
    localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [STALL_W-1:0] stall;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state     <= IDLE;
            route     <= '0;
            pkt_count <= '0;
            dest_err  <= 1'b0;
`ifdef AXIS_DEMUX_ROUTE_TIMEOUT_EN
            stall     <= '0;
            timeout   <= 1'b0;
`endif
        end else begin
            dest_err <= 1'b0;
`ifdef AXIS_DEMUX_ROUTE_TIMEOUT_EN
            timeout  <= 1'b0;
`endif
            unique case (state)
                IDLE: begin
                    if (beat) begin
                        dest_err <= ~in_range;
                        if (in_tlast) begin
                            pkt_count <= pkt_count + 16'd1;
                        end else begin
                            route <= sel;
                            state <= BUSY;
`ifdef AXIS_DEMUX_ROUTE_TIMEOUT_EN
                            stall <= '0;
`endif
                        end
                    end
                end
                BUSY: begin
                    if (beat) begin
`ifdef AXIS_DEMUX_ROUTE_TIMEOUT_EN
                        stall <= '0;
`endif
                        if (in_tlast) begin
                            pkt_count <= pkt_count + 16'd1;
                            state     <= IDLE;
                        end
                    end
`ifdef AXIS_DEMUX_ROUTE_TIMEOUT_EN
                    // Abandon the packet uncounted once the stall limit is reached
                    else if (stall == STALL_W'(TIMEOUT_CYCLES - 1)) begin
                        stall   <= '0;
                        timeout <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        stall <= stall + 1'b1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/axis_demux_route_ctrl.md
AXIS_DEMUX_ROUTE_CTRL -- requirements
Module: axis_demux_route_ctrl

Interface
REQ-001 SHALL have parameter CHANNEL_NUMBER, default 5: number of demux output channels.
REQ-002 SHALL have parameter CHANNEL_NUMBER_WIDTH, default $clog2(CHANNEL_NUMBER): ctrl width.
REQ-003 SHALL have parameter DEST_WIDTH, default 4: TDEST width.
REQ-004 SHALL have parameter DEFAULT_CHANNEL, default 0: channel for out-of-range TDEST.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 256: stall limit, used only with REQ-030.
REQ-006 SHALL have port aclk, input, 1: the single clock; all state changes on its rising edge.
REQ-007 SHALL have port aresetn, input, 1: reset, asynchronous, active-low.
REQ-008 SHALL have port in_tvalid, input, 1: TVALID of the upstream stream feeding the demux.
REQ-009 SHALL have port in_tready, input, 1: TREADY returned to upstream by the demux.
REQ-010 SHALL have port in_tlast, input, 1: TLAST of upstream stream.
REQ-011 SHALL have port in_tdest, input, DEST_WIDTH: TDEST of upstream stream.
REQ-012 SHALL have port en, output, 1: demux enable.
REQ-013 SHALL have port ctrl, output, CHANNEL_NUMBER_WIDTH: demux channel select.
REQ-014 SHALL have port busy, output, 1: high while in BUSY state.
REQ-015 SHALL have port dest_err, output, 1: one-cycle pulse on out-of-range first beat.
REQ-016 SHALL have port pkt_count, output, 16: completed-packet counter, wraps 0xFFFF->0x0000.

Function
REQ-017 SHALL define beat = in_tvalid & in_tready sampled at a rising edge of aclk.
REQ-018 SHALL implement states IDLE and BUSY, packet-granular routing (no channel change inside a packet).
REQ-019 SHALL compute sel = in_tdest if in_tdest < CHANNEL_NUMBER, else DEFAULT_CHANNEL (full-width compare, no truncation).
REQ-020 In IDLE SHALL drive en = in_tvalid and ctrl = sel combinationally (zero-latency first beat).
REQ-021 In IDLE, beat with in_tlast=0 SHALL latch sel into route register and go to BUSY.
REQ-022 In IDLE, beat with in_tlast=1 (single-beat packet) SHALL stay IDLE and increment pkt_count.
REQ-023 In BUSY SHALL drive en=1 and ctrl = route register, ignoring in_tdest.
REQ-024 In BUSY, beat with in_tlast=1 SHALL go to IDLE and increment pkt_count; ctrl SHALL change at earliest the cycle after.
REQ-025 dest_err SHALL pulse for exactly the cycle after an IDLE beat whose in_tdest >= CHANNEL_NUMBER.
REQ-026 in_tvalid low in BUSY (upstream bubble) SHALL hold state, route and en.
REQ-027 in_tvalid deassertion without beat in IDLE SHALL leave state unchanged (no route latched).
REQ-028 pkt_count increment and dest_err on the same beat SHALL both occur.

Reset
REQ-029 aresetn low SHALL asynchronously force IDLE, route=0, pkt_count=0, dest_err=0, busy=0; en and ctrl then follow REQ-020 (en=0 while in_tvalid=0); reset mid-packet SHALL discard the packet without counting it.

Configuration
REQ-030 With macro AXIS_DEMUX_ROUTE_TIMEOUT_EN defined, a stall counter SHALL count BUSY cycles without a beat, clear on each beat and on entering BUSY, and at TIMEOUT_CYCLES consecutive stall cycles force IDLE (packet not counted), plus pulse output timeout for one cycle.
REQ-031 Without AXIS_DEMUX_ROUTE_TIMEOUT_EN, counter and timeout port SHALL be absent and BUSY SHALL persist indefinitely until a TLAST beat.

Verification
REQ-032 Reset, in_tvalid=0 -> en=0, busy=0, pkt_count=0, dest_err=0.
REQ-033 4-beat packet tdest=3, ready always high, tdest changed to 1 on beats 2-4 -> ctrl=3 all 4 beats, busy for beats 2-4, pkt_count=1.
REQ-034 Single-beat packet tdest=2 tlast=1 -> en=1 ctrl=2 same cycle, busy stays 0, pkt_count +1.
REQ-035 tdest=7 with CHANNEL_NUMBER=5 -> ctrl=DEFAULT_CHANNEL (0), dest_err pulses 1 cycle after first beat.
REQ-036 aresetn pulsed low mid-packet in BUSY -> immediate IDLE, busy=0, pkt_count unchanged at 0.
REQ-037 With AXIS_DEMUX_ROUTE_TIMEOUT_EN, TIMEOUT_CYCLES=8, packet stalled after beat 1 -> timeout pulse after 8 stall cycles, busy=0, pkt_count unchanged.
